// File: rtl/axis_lane_packer.sv
// AXI-Stream lane compactor: kept input lanes go into a lane FIFO in order,
// and leave as dense low-aligned beats with a partial final beat per packet.
module axis_lane_packer #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4,
    parameter int DEPTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANE_W*LANES-1:0] s_data,
    input  logic [LANES-1:0]        s_keep,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [LANE_W*LANES-1:0] m_data,
    output logic [LANES-1:0]        m_keep,
    output logic                    m_valid,
    output logic                    m_last,
    input  logic                    m_ready,
    output logic [$clog2(DEPTH):0]  fill_lanes,
    output logic [7:0]              drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam int CW = $clog2(LANES) + 1;
    localparam logic [FW-1:0] L_DEPTH = FW'(DEPTH);
    localparam logic [FW-1:0] L_LANES = FW'(LANES);

    logic [LANE_W-1:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]        r_flag;
    logic [PW-1:0]           r_wrPtr;
    logic [PW-1:0]           r_rdPtr;
    logic [FW-1:0]           r_fill;
    logic                    r_open;
    logic [7:0]              r_dropCnt;
    logic [LANE_W*LANES-1:0] r_mData;
    logic [LANES-1:0]        r_mKeep;
    logic                    r_mValid;
    logic                    r_mLast;

    logic                    w_accept;
    logic [FW-1:0]           w_space;
    logic [CW-1:0]           w_laneOff [LANES];
    logic [PW-1:0]           w_wrAddr [LANES];
    logic [CW-1:0]           w_wrCnt;
    logic [PW-1:0]           w_lastAddr;
    logic                    w_setFlag;
    logic                    w_drop;
    logic [PW-1:0]           w_headIdx [LANES];
    logic [CW-1:0]           w_rdCnt;
    logic                    w_rdLast;
    logic                    w_eligible;
    logic                    w_load;
    logic [LANE_W*LANES-1:0] w_beat;
    logic [LANES-1:0]        w_beatKeep;
    logic [FW-1:0]           w_inCnt;
    logic [FW-1:0]           w_outCnt;

    assign w_space  = L_DEPTH - r_fill;
    assign s_ready  = rst && (w_space >= L_LANES);
    assign w_accept = s_valid && s_ready;

    // Each kept lane lands at wrPtr plus the number of kept lanes below it.
    always_comb begin
        w_wrCnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_laneOff[i] = w_wrCnt;
            w_wrAddr[i]  = r_wrPtr + PW'(w_laneOff[i]);
            if (s_keep[i]) w_wrCnt = w_wrCnt + CW'(1);
        end
    end

    // With keep==0 this collapses to wrPtr-1, the tail of the open packet.
    assign w_lastAddr = r_wrPtr + PW'(w_wrCnt) - PW'(1);
    assign w_setFlag  = w_accept && s_last && ((|s_keep) || r_open);
    assign w_drop     = w_accept && s_last && !(|s_keep) && !r_open;

    // Head scan: stop at the first packet end, otherwise read a full beat
    // only when one more lane is buffered behind it.
    always_comb begin
        w_rdCnt    = '0;
        w_rdLast   = 1'b0;
        w_eligible = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            w_headIdx[j] = r_rdPtr + PW'(j);
        end
        for (int j = LANES - 1; j >= 0; j--) begin
            if ((FW'(j) < r_fill) && r_flag[w_headIdx[j]]) begin
                w_rdCnt  = CW'(j + 1);
                w_rdLast = 1'b1;
            end
        end
        if (w_rdLast) begin
            w_eligible = 1'b1;
        end else if (r_fill > L_LANES) begin
            w_rdCnt    = CW'(LANES);
            w_eligible = 1'b1;
        end
    end

    assign w_load = (!r_mValid || m_ready) && w_eligible;

    always_comb begin
        w_beat     = '0;
        w_beatKeep = '0;
        for (int j = 0; j < LANES; j++) begin
            if (CW'(j) < w_rdCnt) begin
                w_beat[j*LANE_W +: LANE_W] = r_mem[w_headIdx[j]];
                w_beatKeep[j]              = 1'b1;
            end
        end
    end

    assign w_inCnt  = w_accept ? FW'(w_wrCnt) : '0;
    assign w_outCnt = w_load ? FW'(w_rdCnt) : '0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (s_keep[i]) r_mem[w_wrAddr[i]] <= s_data[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flag    <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fill    <= '0;
            r_open    <= 1'b0;
            r_dropCnt <= '0;
            r_mData   <= '0;
            r_mKeep   <= '0;
            r_mValid  <= 1'b0;
            r_mLast   <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    if (s_keep[i]) r_flag[w_wrAddr[i]] <= 1'b0;
                end
                if (w_setFlag) r_flag[w_lastAddr] <= 1'b1;
                r_wrPtr <= r_wrPtr + PW'(w_wrCnt);
                if (s_last) begin
                    r_open <= 1'b0;
                end else if (|s_keep) begin
                    r_open <= 1'b1;
                end
                if (w_drop) r_dropCnt <= r_dropCnt + 8'd1;
            end
            r_fill <= r_fill + w_inCnt - w_outCnt;
            if (w_load) begin
                r_rdPtr  <= r_rdPtr + PW'(w_rdCnt);
                r_mData  <= w_beat;
                r_mKeep  <= w_beatKeep;
                r_mLast  <= w_rdLast;
                r_mValid <= 1'b1;
            end else if (m_ready) begin
                r_mValid <= 1'b0;
            end
        end
    end

    assign m_data     = r_mData;
    assign m_keep     = r_mKeep;
    assign m_valid    = r_mValid;
    assign m_last     = r_mLast;
    assign fill_lanes = r_fill;
    assign drop_cnt   = r_dropCnt;

endmodule
